// File: rtl/pdemux.sv
// Eight-channel write demultiplexer with per-channel full flags, consume/clear
// handshake and saturating accepted-write / stalled-cycle counters.
module pdemux #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       sel_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_0_o,
    output logic [WIDTH-1:0] q_1_o,
    output logic [WIDTH-1:0] q_2_o,
    output logic [WIDTH-1:0] q_3_o,
    output logic [WIDTH-1:0] q_4_o,
    output logic [WIDTH-1:0] q_5_o,
    output logic [WIDTH-1:0] q_6_o,
    output logic [WIDTH-1:0] q_7_o,
    output logic [7:0]       full_o,
    input  logic [7:0]       clr_i,
    output logic [15:0]      wr_cnt_o,
    output logic [15:0]      drop_cnt_o
);

    logic [WIDTH-1:0] chan_q [8];
    logic [7:0]       full_q;
    logic [15:0]      wr_cnt_q;
    logic [15:0]      drop_cnt_q;
    logic             accept;
    logic             stall;
    logic [7:0]       wr_onehot;

    // A full channel still accepts when it is being consumed in the same cycle.
    always_comb begin
        ready_o   = ~full_q[sel_i] | clr_i[sel_i];
        accept    = valid_i & ready_o;
        stall     = valid_i & ~ready_o;
        wr_onehot = 8'h00;
        if (accept) begin
            wr_onehot[sel_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 8; k++) begin
                chan_q[k] <= '0;
            end
            full_q     <= 8'h00;
            wr_cnt_q   <= 16'h0000;
            drop_cnt_q <= 16'h0000;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (wr_onehot[k]) begin
                    chan_q[k] <= data_i;
                end
            end
            // Clear first, then set: a same-cycle consume and refill leaves the flag high.
            full_q <= (full_q & ~clr_i) | wr_onehot;
            if (accept && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (stall && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign q_0_o      = chan_q[0];
    assign q_1_o      = chan_q[1];
    assign q_2_o      = chan_q[2];
    assign q_3_o      = chan_q[3];
    assign q_4_o      = chan_q[4];
    assign q_5_o      = chan_q[5];
    assign q_6_o      = chan_q[6];
    assign q_7_o      = chan_q[7];
    assign full_o     = full_q;
    assign wr_cnt_o   = wr_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_pdemux.sv
// Self-checking bench for pdemux: directed scenarios plus random traffic,
// compared against a simple behavioural model of the channel store.
module tb_pdemux;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic             ready;
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [7:0]       full;
    logic [7:0]       clr;
    logic [15:0]      wr_cnt;
    logic [15:0]      drop_cnt;
    logic [WIDTH-1:0] q_obs [8];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [WIDTH-1:0] m_q [8];
    logic [7:0]       m_full;
    int               m_wr;
    int               m_drop;

    always #5 clk = ~clk;

    pdemux #(.WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
        .sel_i(sel), .data_i(data),
        .q_0_o(q0), .q_1_o(q1), .q_2_o(q2), .q_3_o(q3),
        .q_4_o(q4), .q_5_o(q5), .q_6_o(q6), .q_7_o(q7),
        .full_o(full), .clr_i(clr), .wr_cnt_o(wr_cnt), .drop_cnt_o(drop_cnt)
    );

    assign q_obs[0] = q0;
    assign q_obs[1] = q1;
    assign q_obs[2] = q2;
    assign q_obs[3] = q3;
    assign q_obs[4] = q4;
    assign q_obs[5] = q5;
    assign q_obs[6] = q6;
    assign q_obs[7] = q7;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_q%0d", tag, k), 32'(q_obs[k]), 32'(m_q[k]));
        end
        check({tag, "_full"}, 32'(full), 32'(m_full));
        check({tag, "_wr"}, 32'(wr_cnt), m_wr);
        check({tag, "_drop"}, 32'(drop_cnt), m_drop);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_q[k] = '0;
        m_full = 8'h00;
        m_wr   = 0;
        m_drop = 0;
    endtask

    // One clock cycle: drive, check ready, clock, update model, check all outputs.
    task automatic step(input string tag, input logic r, input logic v, input logic [2:0] s,
                        input logic [WIDTH-1:0] d, input logic [7:0] c);
        bit room;
        @(negedge clk);
        rst = r; valid = v; sel = s; data = d; clr = c;
        #1;
        room = (m_full[s] == 1'b0) || (c[s] == 1'b1);
        check({tag, "_ready"}, 32'(ready), 32'(room));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_full = m_full & ~c;
            if (v && room) begin
                m_q[s]    = d;
                m_full[s] = 1'b1;
                m_wr      = (m_wr < 65535) ? m_wr + 1 : 65535;
            end else if (v) begin
                m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] q_before [8];
        rst = 1'b1; valid = 1'b0; sel = '0; data = '0; clr = '0;
        model_reset();

        // Reset state
        step("rst0", 1'b1, 1'b0, 3'd0, '0, 8'h00);
        step("rst1", 1'b1, 1'b1, 3'd5, 16'hBEEF, 8'hFF);
        check("rst_full_const", 32'(full), 32'h0);

        // Single write to channel 3
        step("w3", 1'b0, 1'b1, 3'd3, 16'h00A5, 8'h00);
        check("w3_q3_const", 32'(q3), 32'h00A5);
        check("w3_full_const", 32'(full), 32'h08);
        check("w3_wr_const", 32'(wr_cnt), 32'd1);

        // Stalls against a full channel
        for (int i = 0; i < 4; i++) step("stall", 1'b0, 1'b1, 3'd3, 16'h1234, 8'h00);
        check("stall_drop_const", 32'(drop_cnt), 32'd4);
        check("stall_q3_const", 32'(q3), 32'h00A5);

        // Consume-and-refill in the same cycle
        step("refill", 1'b0, 1'b1, 3'd3, 16'h1234, 8'h08);
        check("refill_q3_const", 32'(q3), 32'h1234);
        check("refill_wr_const", 32'(wr_cnt), 32'd2);

        // Idle sel sweep has no side effects
        for (int i = 0; i < 8; i++) step("idle", 1'b0, 1'b0, 3'(i), 16'hFFFF, 8'h00);

        // Clear everything, twice; data retained
        for (int k = 0; k < 8; k++) q_before[k] = q_obs[k];
        step("clr1", 1'b0, 1'b0, 3'd0, '0, 8'hFF);
        step("clr2", 1'b0, 1'b0, 3'd0, '0, 8'hFF);
        check("clr_full_const", 32'(full), 32'h0);
        check("clr_q3_keep", 32'(q3), 32'(q_before[3]));

        // 1000 back-to-back writes, consuming the previous target each cycle
        step("rst2", 1'b1, 1'b0, 3'd0, '0, 8'h00);
        for (int i = 0; i < 1000; i++) begin
            step("seq", 1'b0, 1'b1, 3'(i % 8), WIDTH'(i),
                 (i == 0) ? 8'h00 : 8'(1 << ((i - 1) % 8)));
        end
        check("seq_wr_const", 32'(wr_cnt), 32'd1000);
        check("seq_drop_const", 32'(drop_cnt), 32'd0);
        check("seq_q7_const", 32'(q7), 32'd999);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 60) == 0), 1'($urandom), 3'($urandom),
                 WIDTH'($urandom), 8'($urandom) & 8'($urandom));
        end

        // Saturate the write counter, then reset during a write
        step("rst3", 1'b1, 1'b0, 3'd0, '0, 8'h00);
        for (int i = 0; i < 65534; i++) begin
            step("fill", 1'b0, 1'b1, 3'(i % 8), WIDTH'(i), 8'(1 << (i % 8)));
        end
        check("fill_wr_const", 32'(wr_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step("sat", 1'b0, 1'b1, 3'(i), 16'h5A5A, 8'(1 << i));
            check("sat_wr_const", 32'(wr_cnt), 32'hFFFF);
        end
        step("midrst", 1'b1, 1'b1, 3'd4, 16'hCAFE, 8'h00);
        check("midrst_wr_const", 32'(wr_cnt), 32'h0);
        check("midrst_full_const", 32'(full), 32'h0);
        check("midrst_q4_const", 32'(q4), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
